// File: rtl/imm_gen_pkg.sv
// Shared RV32I opcode constants, format codes and the immediate sign-extension helper
// for the immediate generator pipeline.
package imm_gen_pkg;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_SYS    = 7'b1110011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;

   typedef enum logic [2:0] {
      FMT_R   = 3'd0,
      FMT_I   = 3'd1,
      FMT_S   = 3'd2,
      FMT_B   = 3'd3,
      FMT_U   = 3'd4,
      FMT_J   = 3'd5,
      FMT_ILL = 3'd7
   } fmt_t;

   // Widest supported immediate; callers truncate to their XLEN.
   function automatic logic [63:0] sext32(input logic [31:0] v);
      return {{32{v[31]}}, v};
   endfunction

endpackage

// File: rtl/imm_decode.sv
// Combinational RV32I format classifier and immediate extractor (instr -> imm, fmt, illegal).
// Every non-zero immediate has instr[31] in bit 31, so one 32->XLEN extension covers all formats.
module imm_decode
   import imm_gen_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm,
   output logic [2:0]      fmt,
   output logic            illegal
);

   logic [31:0] imm32;
   logic        s;
   fmt_t        f;

   assign s = instr[31];

   always_comb begin
      imm32   = '0;
      f       = FMT_ILL;
      illegal = 1'b0;
      case (instr[6:0])
         OP_R: f = FMT_R;
         OP_IMM, OP_LOAD, OP_JALR, OP_SYS: begin
            f     = FMT_I;
            imm32 = {{20{s}}, instr[31:20]};
         end
         OP_STORE: begin
            f     = FMT_S;
            imm32 = {{20{s}}, instr[31:25], instr[11:7]};
         end
         OP_BRANCH: begin
            f     = FMT_B;
            imm32 = {{19{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         end
         OP_LUI, OP_AUIPC: begin
            f     = FMT_U;
            imm32 = {instr[31:12], 12'b0};
         end
         OP_JAL: begin
            f     = FMT_J;
            imm32 = {{11{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         end
         default: illegal = 1'b1;
      endcase
   end

   assign imm = XLEN'(sext32(imm32));
   assign fmt = f;

endmodule

// File: rtl/imm_gen_pipe.sv
// Elastic 1- or 2-stage RV32I immediate generator with a saturating illegal-opcode counter.
// Each stage reloads when empty or draining, so a full pipe streams without bubbles.
module imm_gen_pipe
   import imm_gen_pkg::*;
#(
   parameter int XLEN      = 32,
   parameter int STAGES    = 1,
   parameter int ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [31:0]          in_instr,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [XLEN-1:0]      out_imm,
   output logic [2:0]           out_fmt,
   output logic                 out_illegal,
   input  logic                 err_clr,
   output logic [ERR_CNT_W-1:0] err_count
);

   logic [XLEN-1:0] dec_imm;
   logic [2:0]      dec_fmt;
   logic            dec_ill;
   logic            ill_hs;

   imm_decode #(.XLEN(XLEN)) u_decode (
      .instr   (in_instr),
      .imm     (dec_imm),
      .fmt     (dec_fmt),
      .illegal (dec_ill)
   );

   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      logic            vld_q, ld, dn_rdy, src_vld, src_ill, ill_q;
      logic [XLEN-1:0] src_imm, imm_q;
      logic [2:0]      src_fmt, fmt_q;

      if (i == 0) begin : g_head
         assign src_vld = in_valid;
         assign src_imm = dec_imm;
         assign src_fmt = dec_fmt;
         assign src_ill = dec_ill;
      end else begin : g_body
         assign src_vld = g_stage[i-1].vld_q;
         assign src_imm = g_stage[i-1].imm_q;
         assign src_fmt = g_stage[i-1].fmt_q;
         assign src_ill = g_stage[i-1].ill_q;
      end

      // Readiness ripples back from the output so a full pipe can drain and fill together.
      if (i == STAGES - 1) begin : g_tail
         assign dn_rdy = out_ready;
      end else begin : g_mid
         assign dn_rdy = g_stage[i+1].ld;
      end

      assign ld = !vld_q || dn_rdy;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            vld_q <= 1'b0;
            imm_q <= '0;
            fmt_q <= '0;
            ill_q <= 1'b0;
         end else if (ld) begin
            vld_q <= src_vld;
            if (src_vld) begin
               imm_q <= src_imm;
               fmt_q <= src_fmt;
               ill_q <= src_ill;
            end
         end
      end
   end

   assign in_ready    = g_stage[0].ld;
   assign out_valid   = g_stage[STAGES-1].vld_q;
   assign out_imm     = g_stage[STAGES-1].imm_q;
   assign out_fmt     = g_stage[STAGES-1].fmt_q;
   assign out_illegal = g_stage[STAGES-1].ill_q;

   assign ill_hs = in_valid && in_ready && dec_ill;

   // A clear coinciding with an illegal accept restarts the count at one, not zero.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_count <= '0;
      end else if (err_clr) begin
         err_count <= ill_hs ? ERR_CNT_W'(1) : '0;
      end else if (ill_hs && (err_count != {ERR_CNT_W{1'b1}})) begin
         err_count <= err_count + ERR_CNT_W'(1);
      end
   end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Elastic, pipelined RV32I immediate generator for the processor's decode path.
- Accepts a raw 32-bit instruction and classifies its format (R/I/S/B/U/J or illegal).
- Emits the sign-extended immediate at a configurable data width.
- Uses valid/ready handshakes on both sides, has 1 or 2 register stages, and keeps a saturating illegal-opcode counter.

Parameters:
- XLEN, 32, output immediate width; legal values 32 or 64.
- STAGES, 1, number of register stages; legal values 1 or 2.
- ERR_CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  single clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream presents in_instr.
- in_ready  out  1  block can accept this cycle.
- in_instr  in  32  raw instruction word.
- out_valid  out  1  out_imm/out_fmt/out_illegal valid.
- out_ready  in  1  downstream consumes this cycle.
- out_imm  out  XLEN  sign-extended immediate.
- out_fmt  out  3  format code: R=0, I=1, S=2, B=3, U=4, J=5, ILL=7.
- out_illegal  out  1  opcode not recognised.
- err_clr  in  1  synchronous clear of err_count.
- err_count  out  ERR_CNT_W  number of accepted illegal instructions, saturating.

Behaviour:
- Reset (async, rst=1): all stage valids=0, out_imm=0, out_fmt=0, out_illegal=0, err_count=0. in_ready=1 the first cycle after release. Reset mid-transfer discards all in-flight entries; nothing is replayed.
- Decode on opcode in_instr[6:0]. Stage 0 registers the decode result, not the raw instruction.
  - 0110011 → R, imm=0.
  - 0010011, 0000011, 1100111, 1110011 → I, imm=sext(instr[31:20]).
  - 0100011 → S, imm=sext({instr[31:25], instr[11:7]}).
  - 1100011 → B, imm=sext({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}).
  - 0110111, 0010111 → U, imm=sext({instr[31:12], 12'b0}).
  - 1101111 → J, imm=sext({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}).
  - Any other opcode → ILL, imm=0, out_illegal=1.
- Sign extension always replicates instr[31] up to XLEN-1. U-type at XLEN=64 is sign-extended as well.
- Handshake:
  - Transfer occurs when valid&ready are both high.
  - Each stage loads when it is empty or its contents leave the same cycle.
  - in_ready = !s0_valid | s0_advance, combinational back through the stages; no combinational path from in_valid to out_valid.
  - Once out_valid=1, out_* must hold stable until out_ready=1.
- Latency and throughput: latency is exactly STAGES cycles from input handshake to out_valid when unstalled. Throughput is 1 instruction/cycle. Capacity is STAGES entries; ordering is strictly preserved.
- Full condition: all stages valid and out_ready=0 → in_ready=0. Simultaneous drain-and-fill when full with out_ready=1 → in_ready=1; no bubble is inserted.
- err_count:
  - Increments by 1 on an input handshake whose opcode is illegal.
  - Saturates at 2^ERR_CNT_W-1.
  - err_clr alone → 0.
  - err_clr together with an illegal handshake in the same cycle → 1.
  - At saturation, an illegal handshake without err_clr leaves the counter unchanged.

Decomposition:
- Package imm_gen_pkg holds:
  - the opcode localparams (OP_R, OP_IMM, OP_LOAD, OP_JALR, OP_SYS, OP_STORE, OP_BRANCH, OP_LUI, OP_AUIPC, OP_JAL);
  - the 3-bit fmt_t enum values;
  - a sext width helper.
- One combinational sub-module, imm_decode (instr → imm, fmt, illegal), is instantiated once before stage 0.
- The pipeline and the counter live in imm_gen_pipe.

Test Plan:
- XLEN=32, STAGES=1, out_ready=1:
  - 0xFFF00093 (addi x1,x0,-1) → one cycle later out_imm=0xFFFFFFFF, fmt=1.
  - 0x00000033 → imm=0, fmt=0.
- Stream back-to-back 0xFE112E23, 0xFE000CE3, 0x123452B7 → outputs in order on consecutive cycles:
  - 0xFFFFFFFC fmt=2;
  - 0xFFFFFFF8 fmt=3;
  - 0x12345000 fmt=4.
- XLEN=64: 0x800002B7 → out_imm=0xFFFFFFFF80000000, fmt=4.
- STAGES=2, out_ready=0, offer three instructions:
  - only 2 are accepted and in_ready drops;
  - out_* stay stable while stalled;
  - raise out_ready → all three emerge in order with no loss or duplication.
- ERR_CNT_W=2, send 0x0000007F five times → out_illegal=1 each time and err_count sequence 1,2,3,3,3. Assert err_clr with a sixth illegal → err_count=1.
- Reset sequence:
  - assert rst while the pipe holds 2 entries → out_valid=0 and err_count=0 immediately, without waiting for a clock;
  - after release, no stale entry appears.
